// File: rtl/uart_pkg.sv
// Shared definitions for the UART TX-side arbitration blocks.
package uart_pkg;

    localparam int BYTE_W           = 8;
    localparam int BUSY_TIMEOUT_DEF = 15;

    typedef enum logic [1:0] {
        ARB_IDLE      = 2'd0,
        ARB_START     = 2'd1,
        ARB_WAIT_BUSY = 2'd2,
        ARB_WAIT_IDLE = 2'd3
    } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector with packet lock: a locked owner is the
// only candidate, otherwise the first request after ptr wins (wrapping).
module rr_pick #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    input  logic         lock,
    input  logic [W-1:0] owner,
    output logic         found,
    output logic [W-1:0] index
);

    logic [W-1:0] cand_idx [N];

    // cand_idx[gi] is the requester examined at search position gi+1 after ptr.
    for (genvar gi = 0; gi < N; gi++) begin : g_cand
        assign cand_idx[gi] = W'((int'(ptr) + gi + 1) % N);
    end

    always_comb begin
        found = 1'b0;
        index = '0;
        if (lock) begin
            found = req[owner];
            index = owner;
        end else begin
            // Walk from the farthest position back so the nearest hit wins.
            for (int k = N - 1; k >= 0; k--) begin
                if (req[cand_idx[k]]) begin
                    found = 1'b1;
                    index = cand_idx[k];
                end
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART transmitter among NUM_REQ byte
// sources, pacing on tx_busy and holding the grant across multi-byte packets.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int GW           = $clog2(NUM_REQ),
    parameter int BUSY_TIMEOUT = BUSY_TIMEOUT_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [BYTE_W*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_ack,
    output logic                      tx_start,
    output logic [BYTE_W-1:0]         tx_data,
    input  logic                      tx_busy,
    output logic [GW-1:0]             grant_id,
    output logic                      active,
    output logic                      timeout_err
);

    localparam int CW = $clog2(BUSY_TIMEOUT + 1);

    arb_state_e        state_q, state_d;
    logic [BYTE_W-1:0] tx_data_q, tx_data_d;
    logic [GW-1:0]     grant_q, grant_d;
    logic              last_q, last_d;
    logic              lock_q, lock_d;
    logic [GW-1:0]     owner_q, owner_d;
    logic [GW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              timeout_q, timeout_d;

    logic              pick_found;
    logic [GW-1:0]     pick_idx;

    rr_pick #(
        .N (NUM_REQ),
        .W (GW)
    ) u_rr_pick (
        .req   (req_valid),
        .ptr   (rr_ptr_q),
        .lock  (lock_q),
        .owner (owner_q),
        .found (pick_found),
        .index (pick_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ARB_IDLE;
            tx_data_q <= '0;
            grant_q   <= '0;
            last_q    <= 1'b0;
            lock_q    <= 1'b0;
            owner_q   <= '0;
            rr_ptr_q  <= GW'(NUM_REQ - 1);
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tx_data_q <= tx_data_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            lock_q    <= lock_d;
            owner_q   <= owner_d;
            rr_ptr_q  <= rr_ptr_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        tx_data_d = tx_data_q;
        grant_d   = grant_q;
        last_d    = last_q;
        lock_d    = lock_q;
        owner_d   = owner_q;
        rr_ptr_d  = rr_ptr_q;
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (!tx_busy && pick_found) begin
                    tx_data_d = req_data[pick_idx*BYTE_W +: BYTE_W];
                    grant_d   = pick_idx;
                    last_d    = req_last[pick_idx];
                    state_d   = ARB_START;
                end
            end
            ARB_START: begin
                cnt_d   = '0;
                state_d = ARB_WAIT_BUSY;
            end
            ARB_WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = ARB_WAIT_IDLE;
                end else if (cnt_q == CW'(BUSY_TIMEOUT - 1)) begin
                    // Transmitter never acknowledged: drop the byte and unlock.
                    timeout_d = 1'b1;
                    lock_d    = 1'b0;
                    rr_ptr_d  = grant_q;
                    state_d   = ARB_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ARB_WAIT_IDLE: begin
                if (!tx_busy) begin
                    state_d = ARB_IDLE;
                    if (last_q) begin
                        lock_d   = 1'b0;
                        rr_ptr_d = grant_q;
                    end else begin
                        lock_d  = 1'b1;
                        owner_d = grant_q;
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ack
        assign req_ack[gi] = (state_q == ARB_START) && (grant_q == GW'(gi));
    end

    always_comb begin
        tx_start    = (state_q == ARB_START);
        active      = (state_q != ARB_IDLE);
        tx_data     = tx_data_q;
        grant_id    = grant_q;
        timeout_err = timeout_q;
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: queued byte sources, a simple transmitter model
// and a scoreboard of expected (requester, byte) grants.
module tb_uart_tx_arbiter;

    localparam int N        = 4;
    localparam int GWB      = 2;
    localparam int TO       = 15;
    localparam int BUSY_LEN = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic [N-1:0]     req_valid;
    logic [8*N-1:0]   req_data;
    logic [N-1:0]     req_last;
    logic [N-1:0]     req_ack;
    logic             tx_start;
    logic [7:0]       tx_data;
    logic             tx_busy;
    logic [GWB-1:0]   grant_id;
    logic             active;
    logic             timeout_err;

    uart_tx_arbiter #(
        .NUM_REQ      (N),
        .BUSY_TIMEOUT (TO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ack     (req_ack),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .tx_busy     (tx_busy),
        .grant_id    (grant_id),
        .active      (active),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } byte_t;

    typedef struct packed {
        logic [GWB-1:0] id;
        logic [7:0]     data;
    } exp_t;

    typedef struct {
        string          name;
        logic [N-1:0]   mask;
        int             per_req;
        logic [7:0]     base;
        int             n_exp;
        logic [7:0][GWB-1:0] order;
    } vec_t;

    byte_t src_q [N][$];
    exp_t  sb_q [$];
    bit    tx_dead = 1'b0;
    int    busy_left = 0;
    int    checks = 0;
    int    errors = 0;
    vec_t  vecs [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic monitor();
        exp_t e;
        if (tx_start) begin
            chk("start_while_busy", 32'(tx_busy), 32'd0);
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_start actual grant=%0d data=%02h required=no start",
                         grant_id, tx_data);
            end else begin
                e = sb_q.pop_front();
                $display("txn: grant=%0d data=%02h (expect %0d/%02h)", grant_id, tx_data, e.id, e.data);
                chk("grant_id", 32'(grant_id), 32'(e.id));
                chk("tx_data", 32'(tx_data), 32'(e.data));
                chk("req_ack_onehot", 32'(req_ack), 32'(1 << e.id));
            end
        end else begin
            chk("req_ack_idle", 32'(req_ack), 32'd0);
        end
    endtask

    // Requester sources, transmitter model and output monitor, all on negedge.
    initial begin
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        tx_busy   = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                monitor();
                for (int i = 0; i < N; i++)
                    if (req_ack[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
            end
            if (tx_start && !tx_dead) begin
                tx_busy   = 1'b1;
                busy_left = BUSY_LEN;
            end else if (busy_left > 0) begin
                busy_left--;
                if (busy_left == 0) tx_busy = 1'b0;
            end
            for (int i = 0; i < N; i++) begin
                if (src_q[i].size() > 0) begin
                    req_valid[i]        = 1'b1;
                    req_data[i*8 +: 8]  = src_q[i][0].data;
                    req_last[i]         = src_q[i][0].last;
                end else begin
                    req_valid[i] = 1'b0;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic push_src(input int i, input logic [7:0] d, input logic l);
        byte_t b;
        b.data = d;
        b.last = l;
        src_q[i].push_back(b);
    endtask

    task automatic push_exp(input int i, input logic [7:0] d);
        exp_t e;
        e.id   = GWB'(i);
        e.data = d;
        sb_q.push_back(e);
    endtask

    task automatic apply_reset();
        step();
        rst_n = 1'b0;
        sb_q.delete();
        for (int i = 0; i < N; i++) src_q[i].delete();
        repeat (2) step();
        rst_n = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_tx_start"}, 32'(tx_start), 32'd0);
        chk({tag, "_tx_data"}, 32'(tx_data), 32'd0);
        chk({tag, "_req_ack"}, 32'(req_ack), 32'd0);
        chk({tag, "_grant_id"}, 32'(grant_id), 32'd0);
        chk({tag, "_active"}, 32'(active), 32'd0);
        chk({tag, "_timeout_err"}, 32'(timeout_err), 32'd0);
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        bit src_busy = 1'b1;
        while (n < budget) begin
            src_busy = 1'b0;
            for (int i = 0; i < N; i++) if (src_q[i].size() > 0) src_busy = 1'b1;
            if (sb_q.size() == 0 && !src_busy && !active && !tx_busy) break;
            step();
            n++;
        end
        chk({tag, "_pending"}, 32'(sb_q.size()), 32'd0);
        chk({tag, "_active_end"}, 32'(active), 32'd0);
    endtask

    task automatic wait_src(input string tag, input int i, input int size, input int budget);
        int n = 0;
        while (n < budget && src_q[i].size() != size) begin
            step();
            n++;
        end
        chk(tag, 32'(src_q[i].size()), 32'(size));
    endtask

    task automatic wait_start(input string tag, input int budget);
        int n = 0;
        while (n < budget && !tx_start) begin
            step();
            n++;
        end
        chk(tag, 32'(tx_start), 32'd1);
    endtask

    initial begin
        int   occ [N];
        int   k;
        logic [GWB-1:0] id;

        // Byte of requester i, packet j in row r is base + 2*i + j.
        vecs[0].name = "single";  vecs[0].mask = 4'b0100; vecs[0].per_req = 1;
        vecs[0].base = 8'h4F;     vecs[0].n_exp = 1;      vecs[0].order = '0;
        vecs[0].order[0] = 2;
        vecs[1].name = "fair";    vecs[1].mask = 4'b1111; vecs[1].per_req = 2;
        vecs[1].base = 8'h90;     vecs[1].n_exp = 8;      vecs[1].order = '0;
        for (int j = 0; j < 8; j++) vecs[1].order[j] = GWB'(j % 4);
        vecs[2].name = "pair13";  vecs[2].mask = 4'b1010; vecs[2].per_req = 1;
        vecs[2].base = 8'hA0;     vecs[2].n_exp = 2;      vecs[2].order = '0;
        vecs[2].order[0] = 1;     vecs[2].order[1] = 3;
        vecs[3].name = "pair03";  vecs[3].mask = 4'b1001; vecs[3].per_req = 2;
        vecs[3].base = 8'hB0;     vecs[3].n_exp = 4;      vecs[3].order = '0;
        vecs[3].order[0] = 0; vecs[3].order[1] = 3; vecs[3].order[2] = 0; vecs[3].order[3] = 3;

        #1 rst_n = 1'b0;
        repeat (2) step();
        check_reset_outputs("reset");
        rst_n = 1'b1;

        for (int r = 0; r < 4; r++) begin
            apply_reset();
            foreach (occ[i]) occ[i] = 0;
            for (int e = 0; e < vecs[r].n_exp; e++) begin
                id = vecs[r].order[e];
                push_exp(int'(id), vecs[r].base + 8'(2 * int'(id) + occ[id]));
                occ[id]++;
            end
            for (int i = 0; i < N; i++)
                if (vecs[r].mask[i])
                    for (int j = 0; j < vecs[r].per_req; j++)
                        push_src(i, vecs[r].base + 8'(2 * i + j), 1'b1);
            wait_done(vecs[r].name, 200);
        end

        // Packet lock: requester 1 keeps the grant over a waiting requester 0.
        apply_reset();
        push_exp(1, 8'h41); push_exp(1, 8'h42); push_exp(1, 8'h43); push_exp(0, 8'h30);
        push_src(1, 8'h41, 1'b0); push_src(1, 8'h42, 1'b0); push_src(1, 8'h43, 1'b1);
        wait_src("lock_first_ack", 1, 2, 50);
        push_src(0, 8'h30, 1'b1);
        wait_done("lock", 200);

        // Locked owner stalls: requester 0 must wait for requester 3's last byte.
        apply_reset();
        push_exp(3, 8'h61); push_exp(3, 8'h62); push_exp(0, 8'h30);
        push_src(3, 8'h61, 1'b0);
        wait_src("stall_first_ack", 3, 0, 50);
        push_src(0, 8'h30, 1'b1);
        repeat (25) step();
        chk("stall_no_grant", 32'(sb_q.size()), 32'd2);
        push_src(3, 8'h62, 1'b1);
        wait_done("stall", 200);

        // Timeout: tx_busy never rises for requester 1's byte.
        apply_reset();
        tx_dead = 1'b1;
        push_exp(1, 8'h11); push_exp(2, 8'h22);
        push_src(1, 8'h11, 1'b1); push_src(2, 8'h22, 1'b1);
        wait_start("timeout_start", 50);
        k = 0;
        while (k < 40 && !timeout_err) begin
            step();
            k++;
        end
        chk("timeout_latency", 32'(k), 32'(TO + 1));
        tx_dead = 1'b0;
        wait_done("timeout", 200);
        chk("timeout_sticky", 32'(timeout_err), 32'd1);

        // Reset while the transmitter is busy (WAIT_IDLE).
        apply_reset();
        push_exp(2, 8'h77);
        push_src(2, 8'h77, 1'b1);
        wait_start("rst_start", 50);
        repeat (2) step();
        chk("rst_in_wait_idle", 32'({active, tx_busy}), 32'd3);
        rst_n = 1'b0;
        sb_q.delete();
        for (int i = 0; i < N; i++) src_q[i].delete();
        #1;
        check_reset_outputs("midreset");
        repeat (2) step();
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) begin
            push_exp(i, 8'hC0 + 8'(i));
            push_src(i, 8'hC0 + 8'(i), 1'b1);
        end
        wait_done("post_reset", 200);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin scheduler that shares a single RS-232 transmitter among `NUM_REQ` byte-stream requesters. It accepts bytes through a valid/ack handshake and drives the transmitter's start strobe and data byte. It paces each byte on the transmitter's busy flag and holds the grant across multi-byte packets until the requester marks the last byte. It sits between on-chip message sources (status, debug, command echo) and the UART TX serializer.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `GW`, `$clog2(NUM_REQ)`: grant index width.
- `BUSY_TIMEOUT`, 15: cycles allowed for `tx_busy` to rise after `tx_start`; counter width `$clog2(BUSY_TIMEOUT+1)`.

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in NUM_REQ: requester i has a byte pending.
- `req_data` in 8*NUM_REQ: byte of requester i at bits [8i+7:8i]; held stable while valid and not acked.
- `req_last` in NUM_REQ: byte is the last of its packet; sampled with data.
- `req_ack` out NUM_REQ: one-cycle pulse, byte of requester i captured.
- `tx_start` out 1: one-cycle start strobe to the transmitter.
- `tx_data` out 8: byte to transmit; stable from `tx_start` until the next capture.
- `tx_busy` in 1: transmitter busy; rises at most one cycle after `tx_start` in a healthy system.
- `grant_id` out GW: index of the current or last granted requester.
- `active` out 1: high in every state except IDLE.
- `timeout_err` out 1: sticky; set when `tx_busy` fails to rise in time.

## Operation
- FSM states: IDLE, START, WAIT_BUSY, WAIT_IDLE.
- **IDLE.** When `tx_busy`=0 and a candidate exists, the block selects a requester, registers `tx_data`, `grant_id` and the last flag, then goes to START.
  - Candidate when locked: only the lock owner with `req_valid`=1. Other requesters wait even if the owner has dropped valid.
  - Candidate when unlocked: first asserted `req_valid` searching from `rr_ptr+1` upward, wrapping modulo NUM_REQ.
- **START.** `tx_start`=1 and `req_ack[grant_id]`=1 for exactly this cycle. The busy counter clears. Next state is WAIT_BUSY.
- **WAIT_BUSY.**
  - `tx_busy`=1: go to WAIT_IDLE.
  - Otherwise the counter increments. When it reaches BUSY_TIMEOUT: set `timeout_err`, release the lock, set `rr_ptr`=`grant_id`, go to IDLE. The byte is considered dropped.
- **WAIT_IDLE.** On `tx_busy`=0, go to IDLE and update lock state:
  - Captured last=1: lock clears and `rr_ptr`=`grant_id`.
  - Captured last=0: lock set with owner `grant_id`.
- `timeout_err` clears only on reset.
- Reset mid-operation: all state returns to reset values immediately. An in-flight `tx_start` is withdrawn. The transmitter is not reset by this block.

## Timing
- Reset values:
  - `tx_start`=0, `tx_data`=8'h00, `req_ack`=0, `grant_id`=0.
  - `active`=0, `timeout_err`=0, lock=0.
  - `rr_ptr`=NUM_REQ-1, so requester 0 wins first.
  - State IDLE.
- Capture edge at cycle T (IDLE→START). `tx_start` and `req_ack` are high during T+1. Requester may change data at T+2.
- `tx_busy` is normally high at T+2, so WAIT_BUSY lasts one cycle.
- Minimum gap from `tx_busy` falling to the next `tx_start`: 2 cycles. That is one cycle in WAIT_IDLE→IDLE, then capture, then START.
- `req_valid` rising while in START, WAIT_BUSY or WAIT_IDLE is deferred to the next IDLE.
- Simultaneous requests are resolved only by round-robin order. No fixed priority except after reset.
- Outputs are registered; no combinational path exists from inputs to outputs.

## Structure
- Shared package `uart_pkg` holds:
  - the state enum (`ARB_IDLE`, `ARB_START`, `ARB_WAIT_BUSY`, `ARB_WAIT_IDLE`);
  - the byte width constant (8);
  - the default BUSY_TIMEOUT.
- One sub-module: `rr_pick`, a combinational round-robin selector.
  - Inputs: request vector, pointer, lock, owner.
  - Outputs: `found`, `index`.
  - Reused by future RX-side dispatchers.

## Test plan
1. **Single byte:** requester 2 sends 0x53, last=1. Expect `tx_start` one cycle after capture, `tx_data`=0x53, `req_ack[2]` single pulse, `grant_id`=2, and `active` low after `tx_busy` falls.
2. **Fairness:** all four valid continuously, single-byte packets. Expect grant order 0,1,2,3,0,1 with one `tx_start` per busy period.
3. **Packet lock:** requester 1 sends 3 bytes 0x41,0x42,0x43 (last on the third) while requester 0 is also valid. Expect all three bytes from requester 1 before any byte from requester 0.
4. **Locked owner stalls:** requester 3 drops valid between packet bytes while 0 is valid. Expect no grant to 0 until requester 3 sends its last byte.
5. **Timeout:** `tx_busy` held 0 after `tx_start`. Expect `timeout_err`=1 after BUSY_TIMEOUT cycles, return to IDLE, the next requester granted, and `timeout_err` staying 1.
6. **Reset mid-byte:** `rst_n` asserted in WAIT_IDLE. Expect all outputs at reset values immediately. After release, requester 0 has first priority.
